// File: rtl/pipeline_debug_pkg.sv
// Shared definitions for the pipeline debug sequencer.
// Contents: state encoding (ST_*), debug command opcodes (CMD_*), default widths.
package pipeline_debug_pkg;

  localparam int CNT_W_DEF  = 32;
  localparam int STEP_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_HALT  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_t;

endpackage

// File: rtl/pipeline_debug_ctrl_if.sv
// Debug front-end command channel (valid/ready handshake).
// Signals: cmd_valid, cmd_ready, cmd_op[1:0], cmd_arg[STEP_W-1:0].
// Modports: master = debug front end, slave = pipeline_debug_ctrl.
interface pipeline_debug_ctrl_if
  import pipeline_debug_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/dbg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), inc (count enable), clr (zero, wins over inc),
//        count[W-1:0] (holds at all-ones once reached).
module dbg_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_debug_ctrl.sv
// Run/halt/single-step sequencer driving the common stop_debug freeze of the
// 5-stage pipeline, plus a saturating executed-cycle counter.
// Optional feature macro: PIPELINE_DEBUG_BREAKPOINT_EN (PC breakpoint compare,
// bp_skip resume suppression and bp_hit pulse). Undefined: pc_in/bp_addr/bp_en
// are ignored and bp_hit is tied low.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cmd                command channel (slave modport), cmd_ready is always 1
//   halt_detected      HALT opcode in WB this cycle
//   pc_in, bp_addr, bp_en  breakpoint compare inputs
//   stop_debug         registered freeze for all stage registers
//   state_o            00 IDLE, 01 RUN, 10 STEP, 11 DONE
//   cycle_count        unfrozen cycles since reset/CLEAR (saturating)
//   done_pulse, bp_hit, cmd_err  one-cycle event pulses
module pipeline_debug_ctrl
  import pipeline_debug_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_debug_ctrl_if.slave cmd,
  input  logic               halt_detected,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        bp_addr,
  input  logic               bp_en,
  output logic               stop_debug,
  output logic [1:0]         state_o,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done_pulse,
  output logic               bp_hit,
  output logic               cmd_err
);

  state_t            state, state_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic              stop_nxt, done_nxt, err_nxt;
  logic              running;
  logic              cmd_clear;
  logic              bp_stop;

  assign cmd.cmd_ready = 1'b1;
  assign running       = (state == ST_RUN) || (state == ST_STEP);
  // CLEAR reaches the counter even when an event wins the FSM arbitration.
  assign cmd_clear     = cmd.cmd_valid && (cmd.cmd_op == CMD_CLEAR);
  assign state_o       = state;

`ifdef PIPELINE_DEBUG_BREAKPOINT_EN
  logic bp_skip, bp_skip_nxt, bp_match;

  assign bp_match = bp_en && (pc_in == bp_addr);
  // Program halt outranks the breakpoint; bp_skip lets the first cycle of a
  // resumed RUN pass the address it stopped on.
  assign bp_stop  = (state == ST_RUN) && !halt_detected && bp_match && !bp_skip;

  always_comb begin
    bp_skip_nxt = bp_skip;
    if (bp_stop) begin
      bp_skip_nxt = 1'b1;
    end else if (state == ST_RUN) begin
      bp_skip_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bp_skip <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      bp_skip <= bp_skip_nxt;
      bp_hit  <= bp_stop;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{pc_in, bp_addr, bp_en};
  assign bp_stop   = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // Arbitration order: halt_detected > breakpoint > step expiry > command.
  // A command that loses is consumed silently (no cmd_err).
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (state == ST_STEP) begin
      step_nxt = step_cnt - STEP_W'(1);
    end

    if (running && halt_detected) begin
      state_nxt = ST_DONE;
      done_nxt  = 1'b1;
    end else if (bp_stop) begin
      state_nxt = ST_IDLE;
    end else if ((state == ST_STEP) && (step_cnt == STEP_W'(1))) begin
      state_nxt = ST_IDLE;
    end else if (cmd.cmd_valid) begin
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_op == CMD_RUN) begin
            state_nxt = ST_RUN;
          end else if (cmd.cmd_op == CMD_STEP) begin
            state_nxt = ST_STEP;
            // A zero step count still advances one cycle.
            step_nxt  = (cmd.cmd_arg == '0) ? STEP_W'(1) : cmd.cmd_arg;
          end
        end
        ST_RUN, ST_STEP: begin
          if (cmd.cmd_op == CMD_HALT) begin
            state_nxt = ST_IDLE;
          end else if ((cmd.cmd_op == CMD_RUN) || (cmd.cmd_op == CMD_STEP)) begin
            err_nxt = 1'b1;
          end
        end
        default: begin
          if (cmd.cmd_op == CMD_CLEAR) begin
            state_nxt = ST_IDLE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      endcase
    end

    stop_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      stop_debug <= 1'b1;
      step_cnt   <= '0;
      done_pulse <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      stop_debug <= stop_nxt;
      step_cnt   <= step_nxt;
      done_pulse <= done_nxt;
      cmd_err    <= err_nxt;
    end
  end

  dbg_sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!stop_debug),
    .clr   (cmd_clear),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Self-checking bench for pipeline_debug_ctrl: directed command sequences,
// a per-cycle reference model of the sequencer rules, and literal checkpoints.
module tb_pipeline_debug_ctrl;
  localparam int CNT_W   = 8;
  localparam int STEP_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPELINE_DEBUG_BREAKPOINT_EN
  localparam bit BP_BUILT = 1'b1;
`else
  localparam bit BP_BUILT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              halt_detected;
  logic [31:0]       pc_in, bp_addr;
  logic              bp_en;
  logic              stop_debug;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  cycle_count;
  logic              done_pulse, bp_hit, cmd_err;

  pipeline_debug_ctrl_if #(.STEP_W(STEP_W)) cif ();

  pipeline_debug_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd           (cif),
    .halt_detected (halt_detected),
    .pc_in         (pc_in),
    .bp_addr       (bp_addr),
    .bp_en         (bp_en),
    .stop_debug    (stop_debug),
    .state_o       (state_o),
    .cycle_count   (cycle_count),
    .done_pulse    (done_pulse),
    .bp_hit        (bp_hit),
    .cmd_err       (cmd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. mode: 0 idle, 1 run, 2 step, 3 done.
  int m_mode, m_left, m_cnt, m_old;
  bit m_skip, m_done, m_bp, m_err, m_on = 1'b0;
  bit m_live, m_clr, m_bpstop;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_left = 0; m_cnt = 0; m_skip = 0;
      m_done = 0; m_bp = 0; m_err = 0; m_on = 1;
    end else if (m_on) begin
      m_old  = m_mode;
      m_live = (m_old == 1) || (m_old == 2);
      m_clr  = cif.cmd_valid && (cif.cmd_op == 2'd3);
      m_done = 0; m_bp = 0; m_err = 0;
      if (m_clr) m_cnt = 0;
      else if (m_live && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_bpstop = BP_BUILT && (m_old == 1) && !halt_detected && bp_en &&
                 (pc_in == bp_addr) && !m_skip;
      if (m_live && halt_detected) begin
        m_mode = 3; m_done = 1;
      end else if (m_bpstop) begin
        m_mode = 0; m_bp = 1;
      end else if (m_old == 2 && m_left == 1) begin
        m_mode = 0;
      end else if (cif.cmd_valid) begin
        if (m_old == 0) begin
          if (cif.cmd_op == 2'd0) m_mode = 1;
          else if (cif.cmd_op == 2'd1) begin
            m_mode = 2;
            m_left = (cif.cmd_arg == 0) ? 1 : int'(cif.cmd_arg);
          end
        end else if (m_old == 3) begin
          if (cif.cmd_op == 2'd3) m_mode = 0;
          else m_err = 1;
        end else begin
          if (cif.cmd_op == 2'd2) m_mode = 0;
          else if (cif.cmd_op != 2'd3) m_err = 1;
        end
      end
      if (m_old == 2) m_left = m_left - 1;
      if (m_old == 1) m_skip = m_bpstop;
      else if (m_bpstop) m_skip = 1;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("state_o", state_o, m_mode);
      check("stop_debug", stop_debug, (m_mode == 0 || m_mode == 3));
      check("cycle_count", cycle_count, m_cnt);
      check("done_pulse", done_pulse, m_done);
      check("bp_hit", bp_hit, m_bp);
      check("cmd_err", cmd_err, m_err);
      check("cmd_ready", cif.cmd_ready, 1'b1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] arg);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    cyc(1);
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; halt_detected = 1'b0; pc_in = '0; bp_addr = '0; bp_en = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_op = 2'd0; cif.cmd_arg = '0;
    cyc(3);
    rst = 1'b0;
    cyc(5);
    check("lit_reset_state", state_o, 2'b00);
    check("lit_reset_stop", stop_debug, 1'b1);
    check("lit_reset_cnt", cycle_count, 0);

    // STEP 3 then STEP 0
    send(2'd1, 16'd3);
    check("lit_step_state", state_o, 2'b10);
    cyc(5);
    check("lit_step3_cnt", cycle_count, 3);
    check("lit_step3_idle", state_o, 2'b00);
    send(2'd1, 16'd0);
    cyc(3);
    check("lit_step0_cnt", cycle_count, 4);

    // RUN, program halt, illegal RUN in DONE, CLEAR
    send(2'd0, '0);
    cyc(9);
    halt_detected = 1'b1;
    cyc(1);
    halt_detected = 1'b0;
    check("lit_halt_done", state_o, 2'b11);
    check("lit_halt_pulse", done_pulse, 1'b1);
    check("lit_halt_stop", stop_debug, 1'b1);
    cyc(1);
    check("lit_pulse_once", done_pulse, 1'b0);
    send(2'd0, '0);
    check("lit_done_err", cmd_err, 1'b1);
    send(2'd3, '0);
    check("lit_clear_idle", state_o, 2'b00);
    check("lit_clear_cnt", cycle_count, 0);

    // Breakpoint stop and resume over the same address
    bp_en = 1'b1; bp_addr = 32'h40; pc_in = 32'h30;
    send(2'd0, '0);
    for (int i = 0; i < 4; i++) begin
      pc_in = pc_in + 32'd4;
      cyc(1);
    end
    check("lit_bp_hit", bp_hit, BP_BUILT);
    check("lit_bp_state", state_o, BP_BUILT ? 2'b00 : 2'b01);
    cyc(1);
    send(2'd0, '0);
    cyc(1);
    pc_in = 32'h44;
    cyc(2);
    check("lit_bp_resume", state_o, 2'b01);
    send(2'd2, '0);
    bp_en = 1'b0;

    // Same-cycle halt_detected and HALT command
    send(2'd0, '0);
    cyc(2);
    halt_detected = 1'b1;
    send(2'd2, '0);
    halt_detected = 1'b0;
    check("lit_prio_done", state_o, 2'b11);
    check("lit_prio_noerr", cmd_err, 1'b0);
    send(2'd3, '0);

    // CLEAR while running, then CLEAR losing to a halt
    send(2'd0, '0);
    cyc(4);
    send(2'd3, '0);
    check("lit_run_clear", cycle_count, 0);
    cyc(1);
    check("lit_run_clear_inc", cycle_count, 1);
    halt_detected = 1'b1;
    send(2'd3, '0);
    halt_detected = 1'b0;
    check("lit_clear_lose_state", state_o, 2'b11);
    check("lit_clear_lose_cnt", cycle_count, 0);
    send(2'd3, '0);

    // Legal/illegal commands
    send(2'd2, '0);
    check("lit_idle_halt_noerr", cmd_err, 1'b0);
    send(2'd0, '0);
    send(2'd0, '0);
    check("lit_run_run_err", cmd_err, 1'b1);
    send(2'd1, 16'd5);
    send(2'd2, '0);
    send(2'd1, 16'd20);
    send(2'd1, 16'd2);
    check("lit_step_step_err", cmd_err, 1'b1);
    send(2'd2, '0);
    check("lit_step_halt_idle", state_o, 2'b00);

    // Step expiry beats a RUN command in the same cycle
    send(2'd1, 16'd2);
    cyc(1);
    send(2'd0, '0);
    check("lit_expiry_wins", state_o, 2'b00);
    check("lit_expiry_noerr", cmd_err, 1'b0);

    // halt_detected ignored while frozen
    halt_detected = 1'b1;
    cyc(2);
    halt_detected = 1'b0;
    check("lit_frozen_halt", state_o, 2'b00);

    // Saturation
    send(2'd3, '0);
    send(2'd0, '0);
    cyc(CNT_MAX + 20);
    check("lit_sat", cycle_count, CNT_MAX);
    send(2'd2, '0);
    cyc(2);
    check("lit_sat_hold", cycle_count, CNT_MAX);
    send(2'd3, '0);

    // Reset in the middle of a STEP with 7 steps left
    send(2'd1, 16'd10);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("lit_rst_state", state_o, 2'b00);
    check("lit_rst_stop", stop_debug, 1'b1);
    check("lit_rst_cnt", cycle_count, 0);
    check("lit_rst_nodone", done_pulse, 1'b0);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
